free_list: RTL and testbench
============================

// Module: free_list
// PURPOSE
//  Circular FIFO of free physical-register tags for the R10K rename path; sits beside the retire stage.
//  Hands out up to 3 new tags per cycle at dispatch and takes back up to 3 old tags (Told) per cycle at retire.
//  Reports fl_free_count to the retire stage. On fch_rec_enable, squashes all in-flight allocations in one cycle.
// PARAMETERS
//  NUM_FREE  32                       capacity = phys regs - 32 arch regs; power of two, >= 4
//  PTR_W     $clog2(NUM_FREE)         head/tail pointer width
//  CNT_W     $clog2(NUM_FREE+1)       free-count width
// PORTS
//  clock               in   1               single clock, rising edge
//  reset               in   1               asynchronous, active-low
//  fl_dispatch_req     in   3               dispatch request mask; bit2 = oldest slot; contiguous from bit2
//  fl_retire_en_mask   in   3               Retire_EN from retire_stage; bit2 = oldest; contiguous from bit2
//  fl_retire_told      in   3x PHYS_W       old tags freed by retiring slots (same bit order)
//  fch_rec_enable      in   1               precise-state recovery from retire_stage
//  fl_alloc_tag        out  3x PHYS_W       new tags for dispatch slots 2,1,0
//  fl_alloc_grant      out  3               granted subset of fl_dispatch_req
//  fl_free_count       out  CNT_W           free entries currently held
// BEHAVIOUR
//  - Async reset (reset==0): entry[i] = 32+i; head = tail = 0; count = NUM_FREE; no grants.
//  - Reset deasserting mid-cycle takes effect at the next rising edge; no partial update.
//  - Allocation, combinational from registered state:
//    - fl_alloc_tag[2] = entry[head], [1] = entry[head+1], [0] = entry[head+2]; pointer arithmetic mod NUM_FREE.
//    - Grant = request truncated to min(popcount(req), count), keeping the oldest bits first.
//      Example: count==1, req 3'b111 -> grant 3'b100.
//    - Same-cycle retires never feed same-cycle grants.
//    - Grant is forced to 3'b000 while fch_rec_enable==1 or reset==0.
//  - Retire, sequential: for k = 0..nret-1, entry[tail+k] <= Told of the k-th enabled slot, scanning bit2 downward.
//    tail <= tail + nret.
//  - Normal update:
//    - head <= head + ngrant.
//    - count <= count - ngrant + nret.
//    - Arithmetic is done in CNT_W+1 bits.
//    - Assertion: result never exceeds NUM_FREE and never goes negative.
//  - Simultaneous dispatch and retire: both apply in the same cycle.
//    Retire writes never hit slots being read, because granted slots lie in [head, head+count).
//  - Recovery (fch_rec_enable==1):
//    - Retire writes still apply for the retiring group.
//    - head <= tail + nret; count <= NUM_FREE; dispatch is ignored.
//    - Rationale: slots [tail, head) hold in-order new tags of in-flight instructions, which all become free.
//  - Empty (count==0): grant 3'b000, fl_alloc_tag is don't-care, retire still accepted.
//  - Full (count==NUM_FREE): head==tail. A retire in this state is a protocol error, flagged by assertion.
//  - Non-contiguous masks are illegal, flagged by assertion.
// STRUCTURE
//  - Shared package sys_defs: PHYS_W = `SYS_PHYS_REG_ADDR_WIDTH, NUM_ARCH_REGS = 32, SUPERSCALAR = 3,
//    popcount3() function.
//  - Single module, no sub-module. Storage is a flop array entry[NUM_FREE]; head/tail/count are registers.
//  - fl_free_count is driven directly from the count register; it is not combinationally bypassed.
// TESTING
//  1. Reset low then high -> count 32, fl_alloc_tag = {32,33,34}, grant 0.
//  2. req 3'b111 one cycle -> grant 3'b111, tags 32/33/34; next cycle count 29, tags {35,36,37}.
//  3. After 2: retire mask 3'b110, Told {5,9}, with req 3'b100
//     -> grant 3'b100 (tag 35); count 29-1+2 = 30; entry[0]=5, entry[1]=9.
//  4. Drain to count 1, req 3'b111 -> grant 3'b100 only. At count 0 -> grant 3'b000.
//  5. Allocate 5, retire 1, assert fch_rec_enable in the same cycle
//     -> count 32, head == tail+1, next tags start at the entry after the retired slot.
//  6. Wrap: 40 cycles of req 3'b111 plus retire 3'b111 -> pointers wrap mod 32,
//     count steady, tags match a reference queue model.

Source files
------------

// File: rtl/free_list_pkg.sv
// Shared rename-path definitions for the free list: tag width, machine width
// and small mask helpers used by the allocation and retire logic.
`ifndef SYS_PHYS_REG_ADDR_WIDTH
`define SYS_PHYS_REG_ADDR_WIDTH 6
`endif

package free_list_pkg;

    localparam int unsigned PHYS_W        = `SYS_PHYS_REG_ADDR_WIDTH;
    localparam int unsigned NUM_ARCH_REGS = 32;
    localparam int unsigned SUPERSCALAR   = 3;

    // Number of set bits in a 3-slot mask.
    function automatic logic [1:0] popcount3(input logic [2:0] m);
        return {1'b0, m[2]} + {1'b0, m[1]} + {1'b0, m[0]};
    endfunction

    // Mask with the n oldest slots (bit2 downward) set.
    function automatic logic [2:0] oldest_mask(input logic [1:0] n);
        case (n)
            2'd0:    return 3'b000;
            2'd1:    return 3'b100;
            2'd2:    return 3'b110;
            default: return 3'b111;
        endcase
    endfunction

endpackage

// File: rtl/free_list.sv
// Circular free list of physical-register tags for the rename path.
// Hands out up to three tags per cycle from head, takes back up to three
// retired Told tags per cycle at tail, and rolls head back to the retire
// point on precise-state recovery.
module free_list
    import free_list_pkg::*;
#(
    parameter int unsigned NUM_FREE = 32,
    parameter int unsigned PTR_W    = $clog2(NUM_FREE),
    parameter int unsigned CNT_W    = $clog2(NUM_FREE + 1)
) (
    input  logic                         clock,
    input  logic                         reset,
    input  logic [2:0]                   fl_dispatch_req,
    input  logic [2:0]                   fl_retire_en_mask,
    input  logic [2:0][PHYS_W-1:0]       fl_retire_told,
    input  logic                         fch_rec_enable,
    output logic [2:0][PHYS_W-1:0]       fl_alloc_tag,
    output logic [2:0]                   fl_alloc_grant,
    output logic [CNT_W-1:0]             fl_free_count
);

    localparam int unsigned SUM_W = CNT_W + 1;

    logic [PHYS_W-1:0]       entry_q [NUM_FREE];
    logic [PHYS_W-1:0]       entry_d [NUM_FREE];
    logic [PTR_W-1:0]        head_q, head_d;
    logic [PTR_W-1:0]        tail_q, tail_d;
    logic [CNT_W-1:0]        count_q, count_d;

    logic [1:0]              nreq, avail, nfit, ngrant, nret, slot;
    logic [2:0]              grant;
    logic [2:0][PHYS_W-1:0]  ret_tag;
    logic [SUM_W-1:0]        cnt_sum;

    // Three oldest free tags, slot 2 reads the head entry.
    assign fl_alloc_tag[2] = entry_q[head_q];
    assign fl_alloc_tag[1] = entry_q[head_q + PTR_W'(1)];
    assign fl_alloc_tag[0] = entry_q[head_q + PTR_W'(2)];

    assign fl_alloc_grant  = grant;
    assign fl_free_count   = count_q;

    // Grant the oldest requested slots that the registered count can cover.
    always_comb begin
        nreq  = popcount3(fl_dispatch_req);
        avail = (count_q >= CNT_W'(3)) ? 2'd3 : count_q[1:0];
        nfit  = (nreq < avail) ? nreq : avail;
        grant = oldest_mask(nfit) & fl_dispatch_req;
        if (fch_rec_enable || !reset) begin
            grant = '0;
        end
        ngrant = popcount3(grant);
    end

    // Compact the enabled Told tags so the oldest retiring slot lands at tail.
    always_comb begin
        nret    = popcount3(fl_retire_en_mask);
        ret_tag = '0;
        slot    = '0;
        if (fl_retire_en_mask[2]) begin
            ret_tag[slot] = fl_retire_told[2];
            slot          = slot + 2'd1;
        end
        if (fl_retire_en_mask[1]) begin
            ret_tag[slot] = fl_retire_told[1];
            slot          = slot + 2'd1;
        end
        if (fl_retire_en_mask[0]) begin
            ret_tag[slot] = fl_retire_told[0];
        end
    end

    // Next-state pointers, count and retire writes into the ring.
    always_comb begin
        entry_d = entry_q;
        if (nret > 2'd0) entry_d[tail_q]               = ret_tag[0];
        if (nret > 2'd1) entry_d[tail_q + PTR_W'(1)]   = ret_tag[1];
        if (nret > 2'd2) entry_d[tail_q + PTR_W'(2)]   = ret_tag[2];

        tail_d  = tail_q + PTR_W'(nret);
        head_d  = head_q + PTR_W'(ngrant);
        cnt_sum = SUM_W'(count_q) + SUM_W'(nret) - SUM_W'(ngrant);
        count_d = cnt_sum[CNT_W-1:0];

        // Everything between tail and head belongs to squashed in-flight
        // instructions, so after this cycle's retire the whole ring is free.
        if (fch_rec_enable) begin
            head_d  = tail_q + PTR_W'(nret);
            count_d = CNT_W'(NUM_FREE);
        end
    end

    // State registers; reset loads the tags just above the architectural set.
    always_ff @(posedge clock or negedge reset) begin
        if (!reset) begin
            for (int unsigned i = 0; i < NUM_FREE; i++) begin
                entry_q[i] <= PHYS_W'(NUM_ARCH_REGS + i);
            end
            head_q  <= '0;
            tail_q  <= '0;
            count_q <= CNT_W'(NUM_FREE);
        end else begin
            entry_q <= entry_d;
            head_q  <= head_d;
            tail_q  <= tail_d;
            count_q <= count_d;
        end
    end

`ifndef SYNTHESIS
    // An underflow wraps cnt_sum above 2**CNT_W, so one bound covers both cases.
    a_count_bound: assert property (@(posedge clock) disable iff (!reset)
        !fch_rec_enable |-> cnt_sum <= SUM_W'(NUM_FREE));

    a_retire_when_full: assert property (@(posedge clock) disable iff (!reset)
        count_q == CNT_W'(NUM_FREE) |-> nret == 2'd0);

    a_req_contig: assert property (@(posedge clock) disable iff (!reset)
        fl_dispatch_req inside {3'b000, 3'b100, 3'b110, 3'b111});

    a_ret_contig: assert property (@(posedge clock) disable iff (!reset)
        fl_retire_en_mask inside {3'b000, 3'b100, 3'b110, 3'b111});
`endif

endmodule

// File: tb/tb_free_list.sv
// Directed bench for the rename free list: reset image, allocation, mixed
// dispatch/retire, drain to empty, recovery and a long pointer-wrap run.
module tb_free_list;
    import free_list_pkg::*;

    localparam int unsigned NUM_FREE = 32;
    localparam int unsigned CNT_W    = $clog2(NUM_FREE + 1);

    logic                    clock = 1'b0;
    logic                    reset;
    logic [2:0]              fl_dispatch_req;
    logic [2:0]              fl_retire_en_mask;
    logic [2:0][PHYS_W-1:0]  fl_retire_told;
    logic                    fch_rec_enable;
    logic [2:0][PHYS_W-1:0]  fl_alloc_tag;
    logic [2:0]              fl_alloc_grant;
    logic [CNT_W-1:0]        fl_free_count;

    int checks   = 0;
    int failures = 0;

    logic [2:0][PHYS_W-1:0]  exp_tag;
    logic [PHYS_W-1:0]       q [$];
    logic [PHYS_W-1:0]       prev [3];

    free_list #(
        .NUM_FREE (NUM_FREE)
    ) dut (
        .clock             (clock),
        .reset             (reset),
        .fl_dispatch_req   (fl_dispatch_req),
        .fl_retire_en_mask (fl_retire_en_mask),
        .fl_retire_told    (fl_retire_told),
        .fch_rec_enable    (fch_rec_enable),
        .fl_alloc_tag      (fl_alloc_tag),
        .fl_alloc_grant    (fl_alloc_grant),
        .fl_free_count     (fl_free_count)
    );

    always #5 clock = ~clock;

    task automatic drive(input logic [2:0] req, input logic [2:0] rmask,
                         input int t2, input int t1, input int t0, input logic rec);
        fl_dispatch_req   = req;
        fl_retire_en_mask = rmask;
        fl_retire_told[2] = PHYS_W'(t2);
        fl_retire_told[1] = PHYS_W'(t1);
        fl_retire_told[0] = PHYS_W'(t0);
        fch_rec_enable    = rec;
    endtask

    task automatic test_reset;
        reset = 1'b0;
        drive(3'b111, 3'b000, 0, 0, 0, 1'b0);
        repeat (2) @(negedge clock);
        #1;
        checks++;
        if (fl_alloc_grant !== 3'b000) begin
            failures++; $display("FAIL reset_grant_forced: got %b want 000", fl_alloc_grant);
        end
        checks++;
        if (fl_free_count !== CNT_W'(32)) begin
            failures++; $display("FAIL reset_count: got %0d want 32", fl_free_count);
        end
        @(negedge clock);
        reset = 1'b1;
        drive(3'b000, 3'b000, 0, 0, 0, 1'b0);
        #1;
        exp_tag[2] = PHYS_W'(32); exp_tag[1] = PHYS_W'(33); exp_tag[0] = PHYS_W'(34);
        for (int k = 0; k < 3; k++) begin
            checks++;
            if (fl_alloc_tag[k] !== exp_tag[k]) begin
                failures++; $display("FAIL reset_tag%0d: got %0d want %0d", k, fl_alloc_tag[k], exp_tag[k]);
            end
        end
        checks++;
        if (fl_free_count !== CNT_W'(32)) begin
            failures++; $display("FAIL post_reset_count: got %0d want 32", fl_free_count);
        end
        @(negedge clock);
    endtask

    task automatic test_alloc;
        drive(3'b111, 3'b000, 0, 0, 0, 1'b0);
        #1;
        checks++;
        if (fl_alloc_grant !== 3'b111) begin
            failures++; $display("FAIL alloc_grant: got %b want 111", fl_alloc_grant);
        end
        exp_tag[2] = PHYS_W'(32); exp_tag[1] = PHYS_W'(33); exp_tag[0] = PHYS_W'(34);
        for (int k = 0; k < 3; k++) begin
            checks++;
            if (fl_alloc_tag[k] !== exp_tag[k]) begin
                failures++; $display("FAIL alloc_tag%0d: got %0d want %0d", k, fl_alloc_tag[k], exp_tag[k]);
            end
        end
        @(negedge clock);
        drive(3'b000, 3'b000, 0, 0, 0, 1'b0);
        #1;
        checks++;
        if (fl_free_count !== CNT_W'(29)) begin
            failures++; $display("FAIL alloc_count: got %0d want 29", fl_free_count);
        end
        exp_tag[2] = PHYS_W'(35); exp_tag[1] = PHYS_W'(36); exp_tag[0] = PHYS_W'(37);
        for (int k = 0; k < 3; k++) begin
            checks++;
            if (fl_alloc_tag[k] !== exp_tag[k]) begin
                failures++; $display("FAIL alloc_next_tag%0d: got %0d want %0d", k, fl_alloc_tag[k], exp_tag[k]);
            end
        end
    endtask

    task automatic test_retire_dispatch;
        drive(3'b100, 3'b110, 5, 9, 0, 1'b0);
        #1;
        checks++;
        if (fl_alloc_grant !== 3'b100) begin
            failures++; $display("FAIL mix_grant: got %b want 100", fl_alloc_grant);
        end
        checks++;
        if (fl_alloc_tag[2] !== PHYS_W'(35)) begin
            failures++; $display("FAIL mix_tag2: got %0d want 35", fl_alloc_tag[2]);
        end
        @(negedge clock);
        drive(3'b000, 3'b000, 0, 0, 0, 1'b0);
        #1;
        checks++;
        if (fl_free_count !== CNT_W'(30)) begin
            failures++; $display("FAIL mix_count: got %0d want 30", fl_free_count);
        end
    endtask

    // head=4 tail=2 count=30 on entry; 27+2 grants wrap head to 1 (entry[1]=9).
    task automatic test_drain;
        for (int c = 0; c < 9; c++) begin
            drive(3'b111, 3'b000, 0, 0, 0, 1'b0);
            #1;
            checks++;
            if (fl_alloc_grant !== 3'b111) begin
                failures++; $display("FAIL drain_grant cycle %0d: got %b want 111", c, fl_alloc_grant);
            end
            @(negedge clock);
        end
        drive(3'b110, 3'b000, 0, 0, 0, 1'b0);
        #1;
        checks++;
        if (fl_free_count !== CNT_W'(3)) begin
            failures++; $display("FAIL drain_count3: got %0d want 3", fl_free_count);
        end
        checks++;
        if (fl_alloc_grant !== 3'b110) begin
            failures++; $display("FAIL drain_grant110: got %b want 110", fl_alloc_grant);
        end
        @(negedge clock);
        drive(3'b111, 3'b000, 0, 0, 0, 1'b0);
        #1;
        checks++;
        if (fl_free_count !== CNT_W'(1)) begin
            failures++; $display("FAIL drain_count1: got %0d want 1", fl_free_count);
        end
        checks++;
        if (fl_alloc_grant !== 3'b100) begin
            failures++; $display("FAIL drain_grant_one_left: got %b want 100", fl_alloc_grant);
        end
        checks++;
        if (fl_alloc_tag[2] !== PHYS_W'(9)) begin
            failures++; $display("FAIL drain_recycled_tag: got %0d want 9", fl_alloc_tag[2]);
        end
        @(negedge clock);
        drive(3'b111, 3'b000, 0, 0, 0, 1'b0);
        #1;
        checks++;
        if (fl_free_count !== CNT_W'(0)) begin
            failures++; $display("FAIL empty_count: got %0d want 0", fl_free_count);
        end
        checks++;
        if (fl_alloc_grant !== 3'b000) begin
            failures++; $display("FAIL empty_grant: got %b want 000", fl_alloc_grant);
        end
        drive(3'b111, 3'b100, 7, 0, 0, 1'b0);
        #1;
        checks++;
        if (fl_alloc_grant !== 3'b000) begin
            failures++; $display("FAIL empty_retire_no_bypass: got %b want 000", fl_alloc_grant);
        end
        @(negedge clock);
        drive(3'b000, 3'b000, 0, 0, 0, 1'b0);
        #1;
        checks++;
        if (fl_free_count !== CNT_W'(1)) begin
            failures++; $display("FAIL empty_retire_count: got %0d want 1", fl_free_count);
        end
        checks++;
        if (fl_alloc_tag[2] !== PHYS_W'(7)) begin
            failures++; $display("FAIL empty_retire_tag: got %0d want 7", fl_alloc_tag[2]);
        end
        @(negedge clock);
    endtask

    // Fresh reset, allocate 5, then retire one (Told 20) with recovery.
    task automatic test_recovery;
        reset = 1'b0;
        drive(3'b000, 3'b000, 0, 0, 0, 1'b0);
        @(negedge clock);
        reset = 1'b1;
        drive(3'b111, 3'b000, 0, 0, 0, 1'b0);
        #1;
        checks++;
        if (fl_alloc_grant !== 3'b111) begin
            failures++; $display("FAIL rec_alloc3: got %b want 111", fl_alloc_grant);
        end
        @(negedge clock);
        drive(3'b110, 3'b000, 0, 0, 0, 1'b0);
        #1;
        checks++;
        if (fl_alloc_grant !== 3'b110 || fl_alloc_tag[2] !== PHYS_W'(35) || fl_alloc_tag[1] !== PHYS_W'(36)) begin
            failures++; $display("FAIL rec_alloc2: got grant %b tags %0d,%0d want 110 tags 35,36",
                                 fl_alloc_grant, fl_alloc_tag[2], fl_alloc_tag[1]);
        end
        @(negedge clock);
        drive(3'b111, 3'b100, 20, 0, 0, 1'b1);
        #1;
        checks++;
        if (fl_free_count !== CNT_W'(27)) begin
            failures++; $display("FAIL rec_pre_count: got %0d want 27", fl_free_count);
        end
        checks++;
        if (fl_alloc_grant !== 3'b000) begin
            failures++; $display("FAIL rec_grant_forced: got %b want 000", fl_alloc_grant);
        end
        @(negedge clock);
        drive(3'b000, 3'b000, 0, 0, 0, 1'b0);
        #1;
        checks++;
        if (fl_free_count !== CNT_W'(32)) begin
            failures++; $display("FAIL rec_count: got %0d want 32", fl_free_count);
        end
        exp_tag[2] = PHYS_W'(33); exp_tag[1] = PHYS_W'(34); exp_tag[0] = PHYS_W'(35);
        for (int k = 0; k < 3; k++) begin
            checks++;
            if (fl_alloc_tag[k] !== exp_tag[k]) begin
                failures++; $display("FAIL rec_tag%0d: got %0d want %0d", k, fl_alloc_tag[k], exp_tag[k]);
            end
        end
    endtask

    // Continuous 3-wide allocate/retire; reference is an ordered queue of free tags.
    task automatic test_back_to_back;
        q.delete();
        for (int i = 1; i < 32; i++) q.push_back(PHYS_W'(32 + i));
        q.push_back(PHYS_W'(20));
        @(negedge clock);
        drive(3'b111, 3'b000, 0, 0, 0, 1'b0);
        #1;
        checks++;
        if (fl_alloc_grant !== 3'b111 || fl_alloc_tag[2] !== q[0] || fl_alloc_tag[1] !== q[1] || fl_alloc_tag[0] !== q[2]) begin
            failures++; $display("FAIL wrap_first: got grant %b tags %0d,%0d,%0d want 111 tags %0d,%0d,%0d",
                                 fl_alloc_grant, fl_alloc_tag[2], fl_alloc_tag[1], fl_alloc_tag[0], q[0], q[1], q[2]);
        end
        for (int k = 0; k < 3; k++) prev[k] = q.pop_front();
        @(negedge clock);
        for (int c = 0; c < 40; c++) begin
            drive(3'b111, 3'b111, int'(prev[0]), int'(prev[1]), int'(prev[2]), 1'b0);
            #1;
            checks++;
            if (fl_alloc_grant !== 3'b111) begin
                failures++; $display("FAIL wrap_grant cycle %0d: got %b want 111", c, fl_alloc_grant);
            end
            checks++;
            if (fl_free_count !== CNT_W'(29)) begin
                failures++; $display("FAIL wrap_count cycle %0d: got %0d want 29", c, fl_free_count);
            end
            for (int k = 0; k < 3; k++) begin
                checks++;
                if (fl_alloc_tag[2-k] !== q[k]) begin
                    failures++; $display("FAIL wrap_tag cycle %0d slot %0d: got %0d want %0d", c, 2-k, fl_alloc_tag[2-k], q[k]);
                end
            end
            for (int k = 0; k < 3; k++) q.push_back(prev[k]);
            for (int k = 0; k < 3; k++) prev[k] = q.pop_front();
            @(negedge clock);
        end
        drive(3'b000, 3'b000, 0, 0, 0, 1'b0);
        #1;
        checks++;
        if (fl_free_count !== CNT_W'(29)) begin
            failures++; $display("FAIL wrap_final_count: got %0d want 29", fl_free_count);
        end
    endtask

    initial begin
        #100000;
        $display("FAIL watchdog: simulation exceeded time limit");
        $fatal(1, "watchdog");
    end

    initial begin
        reset = 1'b0;
        drive(3'b000, 3'b000, 0, 0, 0, 1'b0);
        test_reset();
        test_alloc();
        test_retire_dispatch();
        test_drain();
        test_recovery();
        test_back_to_back();
        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end

endmodule
